// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM initiator (sram_ctrl).
package sram_ctrl_pkg;

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SRCO_W = 5;

  // SRCO pin bit positions, all active-low
  localparam int unsigned SRCO_CE_N = 4;
  localparam int unsigned SRCO_OE_N = 3;
  localparam int unsigned SRCO_WE_N = 2;
  localparam int unsigned SRCO_UB_N = 1;
  localparam int unsigned SRCO_LB_N = 0;

  localparam logic [SRCO_W-1:0] SRCO_IDLE = 5'h1F;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_WAIT_S  = 3'd1,
    RD_SAMPLE  = 3'd2,
    WR_SETUP   = 3'd3,
    WR_PULSE_S = 3'd4,
    WR_HOLD    = 3'd5,
    DONE       = 3'd6
  } state_t;

endpackage

// File: rtl/sram_ctrl_timer.sv
// Loadable 3-bit down-counter with a zero flag; times the read wait and write pulse dwell.
module sram_ctrl_timer
  import sram_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at zero rather than wrapping
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// req/ack word interface to 16-bit asynchronous SRAM pin timing, all pins registered.
// Optional feature: define SRAM_CTRL_POSTED_WR_EN to acknowledge writes one cycle after accept.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned AW       = 18,
  parameter int unsigned DW       = 16,
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_PULSE = 1
) (
  input  logic              RCLK,
  input  logic              RST_N,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wdata,
  output logic              ack,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic [SRCO_W-1:0] SRCO,
  output logic [AW-1:0]     SRAA,
  inout  wire  [DW-1:0]     SRDB
);

`ifdef SRAM_CTRL_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  localparam bit               RD_NO_WAIT = (RD_WAIT == 0);
  localparam logic [CNT_W-1:0] RD_LOAD    = RD_NO_WAIT ? '0 : CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD    = CNT_W'(WR_PULSE - 1);

  state_t              r_state, w_state_nxt;
  logic [SRCO_W-1:0]   r_srco, w_srco_nxt;
  logic [AW-1:0]       r_sraa, w_sraa_nxt;
  logic                r_drv, w_drv_nxt;
  logic [DW-1:0]       r_wdq, w_wdq_nxt;
  logic [DW-1:0]       r_rdata, w_rdata_nxt;
  logic                r_ack, w_ack_nxt;
  logic                r_busy;
  logic                w_tmr_load;
  logic [CNT_W-1:0]    w_tmr_val;
  logic                w_tmr_zero;

  sram_ctrl_timer u_timer (
    .i_clk    (RCLK),
    .i_rst_n  (RST_N),
    .i_load   (w_tmr_load),
    .i_val    (w_tmr_val),
    .o_zero_c (w_tmr_zero)
  );

  always_ff @(posedge RCLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_srco  <= SRCO_IDLE;
      r_sraa  <= '0;
      r_drv   <= 1'b0;
      r_wdq   <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_srco  <= w_srco_nxt;
      r_sraa  <= w_sraa_nxt;
      r_drv   <= w_drv_nxt;
      r_wdq   <= w_wdq_nxt;
      r_rdata <= w_rdata_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_srco_nxt  = r_srco;
    w_sraa_nxt  = r_sraa;
    w_drv_nxt   = r_drv;
    w_wdq_nxt   = r_wdq;
    w_rdata_nxt = r_rdata;
    w_ack_nxt   = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;

    case (r_state)
      IDLE: begin
        if (req) begin
          w_sraa_nxt             = addr;
          w_srco_nxt[SRCO_CE_N]  = 1'b0;
          if (we) begin
            w_srco_nxt[SRCO_UB_N] = ~be[1];
            w_srco_nxt[SRCO_LB_N] = ~be[0];
            w_drv_nxt             = 1'b1;
            w_wdq_nxt             = wdata;
            w_state_nxt           = WR_SETUP;
          end else begin
            w_srco_nxt[SRCO_OE_N] = 1'b0;
            w_srco_nxt[SRCO_UB_N] = 1'b0;
            w_srco_nxt[SRCO_LB_N] = 1'b0;
            if (RD_NO_WAIT) begin
              w_state_nxt = RD_SAMPLE;
            end else begin
              w_tmr_load  = 1'b1;
              w_tmr_val   = RD_LOAD;
              w_state_nxt = RD_WAIT_S;
            end
          end
        end
      end
      RD_WAIT_S: begin
        if (w_tmr_zero) w_state_nxt = RD_SAMPLE;
      end
      RD_SAMPLE: begin
        w_rdata_nxt = SRDB;
        w_srco_nxt  = SRCO_IDLE;
        w_ack_nxt   = 1'b1;
        w_state_nxt = DONE;
      end
      WR_SETUP: begin
        // No byte lanes enabled: keep WE_N high so nothing is committed
        if (!(r_srco[SRCO_UB_N] && r_srco[SRCO_LB_N])) w_srco_nxt[SRCO_WE_N] = 1'b0;
        w_tmr_load  = 1'b1;
        w_tmr_val   = WR_LOAD;
        w_ack_nxt   = POSTED;
        w_state_nxt = WR_PULSE_S;
      end
      WR_PULSE_S: begin
        if (w_tmr_zero) begin
          w_srco_nxt[SRCO_WE_N] = 1'b1;
          w_state_nxt           = WR_HOLD;
        end
      end
      WR_HOLD: begin
        w_drv_nxt   = 1'b0;
        w_srco_nxt  = SRCO_IDLE;
        w_ack_nxt   = !POSTED;
        w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign SRDB  = r_drv ? r_wdq : {DW{1'bz}};
  assign SRCO  = r_srco;
  assign SRAA  = r_sraa;
  assign ack   = r_ack;
  assign rdata = r_rdata;
  assign busy  = r_busy;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural asynchronous SRAM on the pins.
// Expected write latency follows SRAM_CTRL_POSTED_WR_EN when the bench is built with it.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

`ifdef SRAM_CTRL_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif
  localparam int WR_LAT = POSTED ? 1 : 3;
  localparam int RD_LAT = 2;
  localparam int WR_GAP = POSTED ? 4 : 2;

  typedef struct {
    bit          rd;
    logic [15:0] data;
    int          lat;
  } exp_t;

  logic        RCLK;
  logic        RST_N;
  logic        req;
  logic        we;
  logic [1:0]  be;
  logic [17:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;
  logic        busy;
  logic [4:0]  SRCO;
  logic [17:0] SRAA;
  wire  [15:0] SRDB;

  logic [15:0] mem [0:255];
  logic [15:0] ref_mem [0:255];
  logic        mem_clr;
  logic [15:0] last_rd;
  int          we_pulses;
  int          vectors;
  int          miscompares;
  exp_t        sb [$];

  sram_ctrl dut (
    .RCLK  (RCLK),
    .RST_N (RST_N),
    .req   (req),
    .we    (we),
    .be    (be),
    .addr  (addr),
    .wdata (wdata),
    .ack   (ack),
    .rdata (rdata),
    .busy  (busy),
    .SRCO  (SRCO),
    .SRAA  (SRAA),
    .SRDB  (SRDB)
  );

  initial RCLK = 1'b0;
  always #10 RCLK = ~RCLK;

  // SRAM model: drives the bus on OE_N low, commits enabled bytes on WE_N rising
  assign SRDB = (!SRCO[SRCO_CE_N] && !SRCO[SRCO_OE_N]) ? mem[SRAA[7:0]] : 16'bz;

  always @(posedge SRCO[SRCO_WE_N] or posedge mem_clr) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    end else if (!SRCO[SRCO_CE_N]) begin
      if (!SRCO[SRCO_UB_N]) mem[SRAA[7:0]][15:8] = SRDB[15:8];
      if (!SRCO[SRCO_LB_N]) mem[SRAA[7:0]][7:0]  = SRDB[7:0];
    end
  end

  always @(negedge SRCO[SRCO_WE_N]) we_pulses++;

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge RCLK);
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_timeout busy=%b required 0", busy);
    end
  endtask

  // mode 0: hold req to ack; 1: drop req after accept; 2: keep req high for a following op
  task automatic do_op(input bit w, input logic [1:0] b, input logic [17:0] a,
                       input logic [15:0] d, input int gap, input int mode, input string nm);
    exp_t e;
    int   k = 0;
    bit   got = 0;
    int   p0 = we_pulses;
    logic [4:0] pins;
    e.rd   = !w;
    e.lat  = w ? WR_LAT : RD_LAT;
    e.data = ref_mem[a[7:0]];
    if (w) begin
      if (b[1]) ref_mem[a[7:0]][15:8] = d[15:8];
      if (b[0]) ref_mem[a[7:0]][7:0]  = d[7:0];
    end
    sb.push_back(e);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    while (!got && k < 24) begin
      @(negedge RCLK);
      k++;
      if (mode == 1 && k == gap) req = 1'b0;
      vectors++;
      if ((SRCO[SRCO_OE_N] | SRCO[SRCO_WE_N]) !== 1'b1) begin
        miscompares++;
        $display("FAIL %s oe_we_overlap SRCO=%h", nm, SRCO);
      end
      if (!w && k == gap) begin
        vectors++;
        if (SRCO !== 5'h04 || SRAA !== a) begin
          miscompares++;
          $display("FAIL %s rd_pins SRCO=%h SRAA=%h required 04 %h", nm, SRCO, SRAA, a);
        end
      end
      if (w && k == gap + 1) begin
        pins = {1'b0, 1'b1, (b == 2'b00), ~b};
        vectors++;
        if (SRCO !== pins || SRAA !== a || SRDB !== d) begin
          miscompares++;
          $display("FAIL %s wr_pins SRCO=%h SRAA=%h SRDB=%h required %h %h %h",
                   nm, SRCO, SRAA, SRDB, pins, a, d);
        end
      end
      if (ack === 1'b1) got = 1;
    end
    e = sb.pop_front();
    vectors++;
    if (!got || k != gap + e.lat) begin
      miscompares++;
      $display("FAIL %s ack_latency got=%0d cycles=%0d required %0d", nm, got, k, gap + e.lat);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_at_ack busy=%b required 1", nm, busy);
    end
    if (e.rd) last_rd = e.data;
    vectors++;
    if (rdata !== last_rd) begin
      miscompares++;
      $display("FAIL %s rdata got %h required %h", nm, rdata, last_rd);
    end
    if (w) begin
      vectors++;
      if (we_pulses - p0 != ((b != 2'b00) ? 1 : 0)) begin
        miscompares++;
        $display("FAIL %s we_pulses got %0d required %0d", nm, we_pulses - p0, (b != 2'b00) ? 1 : 0);
      end
    end
    if (mode != 2) begin
      req = 1'b0;
      @(negedge RCLK);
      vectors++;
      if (ack !== 1'b0) begin
        miscompares++;
        $display("FAIL %s ack_width ack=%b required 0", nm, ack);
      end
      wait_idle();
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge RCLK);
      if (i == 5) RST_N = 1'b1;
      vectors++;
      if (SRCO !== SRCO_IDLE || ack !== 1'b0 || busy !== 1'b0 || rdata !== 16'h0 || SRAA !== 18'h0) begin
        miscompares++;
        $display("FAIL reset_state SRCO=%h ack=%b busy=%b rdata=%h SRAA=%h required 1f 0 0 0 0",
                 SRCO, ack, busy, rdata, SRAA);
      end
    end
    last_rd = 16'h0;
  endtask

  task automatic test_basic();
    do_op(1'b1, 2'b11, 18'h00012, 16'hA55A, 1, 0, "wr_full");
    do_op(1'b0, 2'b11, 18'h00012, 16'h0000, 1, 0, "rd_full");
  endtask

  task automatic test_byte_en();
    do_op(1'b1, 2'b01, 18'h00012, 16'h1234, 1, 0, "wr_lb");
    do_op(1'b0, 2'b11, 18'h00012, 16'h0000, 1, 0, "rd_lb");
    do_op(1'b1, 2'b00, 18'h00012, 16'hFFFF, 1, 1, "wr_no_be");
    do_op(1'b0, 2'b11, 18'h00012, 16'h0000, 1, 0, "rd_no_be");
  endtask

  task automatic test_back_to_back();
    do_op(1'b1, 2'b11, 18'h00030, 16'h1111, 1, 2, "b2b_wr1");
    do_op(1'b0, 2'b11, 18'h00030, 16'h0000, WR_GAP, 2, "b2b_rd");
    do_op(1'b1, 2'b10, 18'h00030, 16'h2222, 2, 0, "b2b_wr2");
    do_op(1'b0, 2'b11, 18'h00030, 16'h0000, 1, 0, "b2b_chk");
  endtask

  task automatic test_reset_mid_op();
    int acks = 0;
    req = 1'b1; we = 1'b1; be = 2'b11; addr = 18'h00020; wdata = 16'hBEEF;
    @(negedge RCLK);
    @(negedge RCLK);
    vectors++;
    if (SRCO !== 5'h08) begin
      miscompares++;
      $display("FAIL rst_wr_pulse_pins SRCO=%h required 08", SRCO);
    end
    RST_N = 1'b0; req = 1'b0;
    @(negedge RCLK);
    vectors++;
    if (SRCO !== SRCO_IDLE || ack !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wr_state SRCO=%h ack=%b busy=%b required 1f 0 0", SRCO, ack, busy);
    end
    RST_N = 1'b1;
    last_rd = 16'h0;
    repeat (6) begin
      @(negedge RCLK);
      if (ack === 1'b1) acks++;
    end
    vectors++;
    if (acks != 0) begin
      miscompares++;
      $display("FAIL rst_wr_no_ack acks=%0d required 0", acks);
    end
    do_op(1'b0, 2'b11, 18'h00020, 16'h0000, 1, 0, "rd_after_wr_rst");
    do_op(1'b0, 2'b11, 18'h00012, 16'h0000, 1, 0, "rd_before_rd_rst");
    req = 1'b1; we = 1'b0; addr = 18'h00012;
    @(negedge RCLK);
    RST_N = 1'b0; req = 1'b0;
    @(negedge RCLK);
    vectors++;
    if (SRCO !== SRCO_IDLE || ack !== 1'b0 || rdata !== 16'h0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rd_state SRCO=%h ack=%b rdata=%h busy=%b required 1f 0 0 0", SRCO, ack, rdata, busy);
    end
    RST_N = 1'b1;
    last_rd = 16'h0;
    acks = 0;
    repeat (4) begin
      @(negedge RCLK);
      if (ack === 1'b1) acks++;
    end
    vectors++;
    if (acks != 0 || rdata !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_rd_no_ack acks=%0d rdata=%h required 0 0", acks, rdata);
    end
  endtask

  task automatic test_posted_wr();
    do_op(1'b1, 2'b11, 18'h00040, 16'h5A5A, 1, 2, "posted_wr");
    do_op(1'b0, 2'b11, 18'h00040, 16'h0000, WR_GAP, 0, "posted_rd");
  endtask

  initial begin
    RST_N = 1'b0; req = 1'b0; we = 1'b0; be = 2'b00; addr = '0; wdata = '0;
    vectors = 0; miscompares = 0; last_rd = 16'h0; mem_clr = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    #1 mem_clr = 1'b1;
    #1 mem_clr = 1'b0;
    test_reset();
    test_basic();
    test_byte_en();
    test_back_to_back();
    test_reset_mid_op();
    test_posted_wr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
